// File: rtl/uart_rx_word_pkg.sv
// Shared constants, state encodings and bus word type for the word-packing UART receiver.
package uart_rx_word_pkg;

  localparam int unsigned UART_DIV_RATE        = 16;
  localparam int unsigned UART_RX_BIT_CNT_STOP = 8;
  localparam int unsigned UART_RX_BIT_CNT_W    = 4;
  localparam int unsigned BYTE_W               = 8;
  localparam int unsigned PAYLOAD_W            = 32;
  localparam int unsigned WORD_W               = PAYLOAD_W + 1;
  localparam int unsigned BUF_W                = 3 * BYTE_W;

  // Line levels match the transmitter's start/stop bits.
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    UART_RX_STATE_IDLE,
    UART_RX_STATE_ARMED,
    UART_RX_STATE_START,
    UART_RX_STATE_DATA,
    UART_RX_STATE_STOP,
    UART_RX_STATE_FLUSH
  } uart_rx_state_e;

  typedef struct packed {
    logic                 parity;
    logic [PAYLOAD_W-1:0] payload;
  } rx_word_t;

  // Even parity so that the full 33-bit word reduces to zero.
  function automatic rx_word_t make_rx_word(input logic [PAYLOAD_W-1:0] payload);
    rx_word_t w;
    w.parity  = ^payload;
    w.payload = payload;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector on the synchronized level.
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall_c
);

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic rx_prev_q, rx_prev_d;

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
  end

  // Idle line level is high, so every stage resets to 1.
  always_ff @(posedge clk) begin
    if (resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  assign rx_s      = rx_s_q;
  assign rx_fall_c = rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_word.sv
// 8N1 receiver that packs four bytes per bus word, appends even parity and hands words out
// over a valid/ready interface for a programmed word count.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int unsigned DIV_RATE   = UART_DIV_RATE,
  parameter int unsigned WORD_NUM_W = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rx,
  input  logic                  start,
  input  logic [WORD_NUM_W-1:0] word_number,
  output logic [WORD_W-1:0]     rx_word_data,
  output logic                  rx_word_valid,
  input  logic                  rx_word_ready,
  output logic                  rx_done,
  output logic                  frame_error,
  output logic                  overrun_error
);

  localparam int unsigned DIV_W = $clog2(DIV_RATE);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV_RATE / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(DIV_RATE - 1);
  localparam logic [UART_RX_BIT_CNT_W-1:0] BIT_LAST = UART_RX_BIT_CNT_W'(UART_RX_BIT_CNT_STOP - 1);

  logic rx_s, rx_fall_c;

  uart_rx_sync u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .rx_s      (rx_s),
    .rx_fall_c (rx_fall_c)
  );

  uart_rx_state_e               state_q, state_d;
  logic [WORD_NUM_W-1:0]        words_left_q, words_left_d;
  logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
  logic [UART_RX_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]            sh_reg_q, sh_reg_d;
  logic [BUF_W-1:0]             word_buf_q, word_buf_d;
  logic [1:0]                   byte_idx_q, byte_idx_d;
  rx_word_t                     rx_word_q, rx_word_d;
  logic                         rx_word_valid_q, rx_word_valid_d;
  logic                         rx_done_q, rx_done_d;
  logic                         frame_error_q, frame_error_d;
  logic                         overrun_error_q, overrun_error_d;
  logic                         xfer_c;

  assign xfer_c = rx_word_valid_q & rx_word_ready;

  always_comb begin
    state_d         = state_q;
    words_left_d    = words_left_q;
    div_cnt_d       = div_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    sh_reg_d        = sh_reg_q;
    word_buf_d      = word_buf_q;
    byte_idx_d      = byte_idx_q;
    rx_word_d       = rx_word_q;
    rx_word_valid_d = rx_word_valid_q;
    rx_done_d       = 1'b0;
    frame_error_d   = frame_error_q;
    overrun_error_d = overrun_error_q;

    if (xfer_c) begin
      rx_word_valid_d = 1'b0;
    end

    unique case (state_q)
      UART_RX_STATE_IDLE: begin
        if (start) begin
          frame_error_d   = 1'b0;
          overrun_error_d = 1'b0;
          if (word_number == '0) begin
            rx_done_d = 1'b1;
          end else begin
            words_left_d = word_number;
            state_d      = UART_RX_STATE_ARMED;
          end
        end
      end
      UART_RX_STATE_ARMED: begin
        if (rx_fall_c) begin
          div_cnt_d = DIV_HALF;
          state_d   = UART_RX_STATE_START;
        end
      end
      // Re-check the start bit at mid-bit; a high level means the edge was a glitch.
      UART_RX_STATE_START: begin
        if (div_cnt_q == '0) begin
          if (rx_s == UART_START_BIT) begin
            bit_cnt_d = '0;
            div_cnt_d = DIV_FULL;
            state_d   = UART_RX_STATE_DATA;
          end else begin
            state_d = UART_RX_STATE_ARMED;
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      UART_RX_STATE_DATA: begin
        if (div_cnt_q == '0) begin
          sh_reg_d  = {rx_s, sh_reg_q[BYTE_W-1:1]};
          div_cnt_d = DIV_FULL;
          bit_cnt_d = bit_cnt_q + UART_RX_BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = UART_RX_STATE_STOP;
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      UART_RX_STATE_STOP: begin
        if (div_cnt_q == '0) begin
          if (rx_s == UART_STOP_BIT) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = UART_RX_STATE_ARMED;
            unique case (byte_idx_q)
              2'd0: word_buf_d[0*BYTE_W +: BYTE_W] = sh_reg_q;
              2'd1: word_buf_d[1*BYTE_W +: BYTE_W] = sh_reg_q;
              2'd2: word_buf_d[2*BYTE_W +: BYTE_W] = sh_reg_q;
              default: begin
                // Lane 3 completes the word; a same-cycle transfer frees the holding register.
                words_left_d = words_left_q - WORD_NUM_W'(1);
                if (rx_word_valid_q && !rx_word_ready) begin
                  overrun_error_d = 1'b1;
                end else begin
                  rx_word_d       = make_rx_word({sh_reg_q, word_buf_q});
                  rx_word_valid_d = 1'b1;
                end
                if (words_left_q == WORD_NUM_W'(1)) begin
                  state_d = UART_RX_STATE_FLUSH;
                end
              end
            endcase
          end else begin
            frame_error_d = 1'b1;
            byte_idx_d    = '0;
            state_d       = UART_RX_STATE_IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end
      end
      UART_RX_STATE_FLUSH: begin
        if (xfer_c) begin
          rx_done_d = 1'b1;
          state_d   = UART_RX_STATE_IDLE;
        end
      end
      default: state_d = UART_RX_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q         <= UART_RX_STATE_IDLE;
      words_left_q    <= '0;
      div_cnt_q       <= '0;
      bit_cnt_q       <= '0;
      sh_reg_q        <= '0;
      word_buf_q      <= '0;
      byte_idx_q      <= '0;
      rx_word_q       <= '0;
      rx_word_valid_q <= 1'b0;
      rx_done_q       <= 1'b0;
      frame_error_q   <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      words_left_q    <= words_left_d;
      div_cnt_q       <= div_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      sh_reg_q        <= sh_reg_d;
      word_buf_q      <= word_buf_d;
      byte_idx_q      <= byte_idx_d;
      rx_word_q       <= rx_word_d;
      rx_word_valid_q <= rx_word_valid_d;
      rx_done_q       <= rx_done_d;
      frame_error_q   <= frame_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  assign rx_word_data  = rx_word_q;
  assign rx_word_valid = rx_word_valid_q;
  assign rx_done       = rx_done_q;
  assign frame_error   = frame_error_q;
  assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Self-checking bench for uart_rx_word: serial byte driver, transfer monitor and a word-level model.
module tb_uart_rx_word;

  localparam int unsigned DIV = 4;
  localparam int unsigned NW  = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          rx = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] word_number = '0;
  logic [32:0]   rx_word_data;
  logic          rx_word_valid;
  logic          rx_word_ready = 1'b0;
  logic          rx_done;
  logic          frame_error;
  logic          overrun_error;

  uart_rx_word #(.DIV_RATE(DIV), .WORD_NUM_W(NW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rx            (rx),
    .start         (start),
    .word_number   (word_number),
    .rx_word_data  (rx_word_data),
    .rx_word_valid (rx_word_valid),
    .rx_word_ready (rx_word_ready),
    .rx_done       (rx_done),
    .frame_error   (frame_error),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ready policy: 0 low, 1 high, 2 random, 3 high from cycle rdy_thr on.
  int          rdy_mode = 0;
  int unsigned rdy_thr = 0;

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       rx_word_ready = 1'b0;
      1:       rx_word_ready = 1'b1;
      2:       rx_word_ready = ($urandom_range(0, 3) != 0);
      default: rx_word_ready = (cyc >= rdy_thr);
    endcase
  end

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  int unsigned xfer_cyc_q[$];
  int unsigned done_cyc_q[$];
  logic        pv = 1'b0, pr = 1'b0, prst = 1'b0;
  logic [32:0] pd = '0;

  // Records transfers and done pulses; a stalled word must not change.
  always @(negedge clk) begin
    if (pv && !pr && !prst) check_eq("hold_stable", {rx_word_valid, rx_word_data}, {1'b1, pd});
    if (rx_word_valid && rx_word_ready) begin
      got_q.push_back(rx_word_data);
      xfer_cyc_q.push_back(cyc);
    end
    if (rx_done) done_cyc_q.push_back(cyc);
    pv   = rx_word_valid;
    pr   = rx_word_ready;
    pd   = rx_word_data;
    prst = resetn;
  end

  function automatic logic [32:0] model_word(input logic [7:0] b0, b1, b2, b3);
    logic [31:0] p;
    p = {b3, b2, b1, b0};
    return {($countones(p) % 2) == 1, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (DIV) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic arm(input int n);
    got_q.delete(); exp_q.delete(); xfer_cyc_q.delete(); done_cyc_q.delete();
    word_number = NW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends four random bytes; with b2b, ready is timed to rise for the final stop-bit sample.
  task automatic send_word(input int gap_max, input bit b2b, output logic [32:0] w);
    logic [7:0] b[4];
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      idle(int'($urandom_range(0, gap_max)));
      if (b2b && i == 3) begin
        rdy_thr  = cyc + 2 + DIV / 2 + 9 * DIV;
        rdy_mode = 3;
      end
      send_byte(b[i], 1'b1);
    end
    w = model_word(b[0], b[1], b[2], b[3]);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (done_cyc_q.size() == 0 && k < budget) begin
      tick();
      k++;
    end
    if (done_cyc_q.size() == 0) check_eq({tag, "_timeout"}, done_cyc_q.size(), 1);
    else idle(3);
  endtask

  task automatic finish_job(input string tag, input logic exp_over);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check_eq({tag, "_word"}, got_q[i], exp_q[i]);
    check_eq({tag, "_done_n"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0 && xfer_cyc_q.size() > 0)
      check_eq({tag, "_done_lat"}, done_cyc_q[0], xfer_cyc_q[$] + 1);
    check_eq({tag, "_overrun"}, overrun_error, exp_over);
    check_eq({tag, "_frame"}, frame_error, 0);
    check_eq({tag, "_valid_end"}, rx_word_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] w1, w2, w;
    int          n;

    idle(3);
    check_eq("rst_data", rx_word_data, 0);
    check_eq("rst_valid", rx_word_valid, 0);
    check_eq("rst_done", rx_done, 0);
    check_eq("rst_frame", frame_error, 0);
    check_eq("rst_overrun", overrun_error, 0);
    resetn = 1'b0;
    idle(3);

    // Directed single word.
    rdy_mode = 1;
    arm(1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    exp_q.push_back(model_word(8'h78, 8'h56, 8'h34, 8'h12));
    wait_done(200, "single");
    if (got_q.size() > 0) check_eq("single_const", got_q[0], 33'h1_12345678);
    finish_job("single", 1'b0);

    // Zero word count.
    arm(0);
    check_eq("zero_done", rx_done, 1);
    tick();
    check_eq("zero_done_pulse", rx_done, 0);
    check_eq("zero_valid", rx_word_valid, 0);

    // Framing error on the second byte, then start clears the flag.
    arm(1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    idle(10);
    check_eq("fe_flag", frame_error, 1);
    check_eq("fe_valid", rx_word_valid, 0);
    check_eq("fe_words", got_q.size(), 0);
    check_eq("fe_done", done_cyc_q.size(), 0);
    arm(1);
    check_eq("fe_cleared", frame_error, 0);
    send_word(3, 1'b0, w);
    exp_q.push_back(w);
    wait_done(300, "fe_next");
    finish_job("fe_next", 1'b0);

    // One-clock glitch while armed.
    arm(1);
    idle(5);
    rx = 1'b0;
    tick();
    rx = 1'b1;
    idle(30);
    check_eq("glitch_frame", frame_error, 0);
    check_eq("glitch_overrun", overrun_error, 0);
    check_eq("glitch_valid", rx_word_valid, 0);
    send_word(3, 1'b0, w);
    exp_q.push_back(w);
    wait_done(300, "glitch");
    finish_job("glitch", 1'b0);

    // Overrun: second word dropped while the first is held.
    rdy_mode = 0;
    arm(2);
    send_word(2, 1'b0, w1);
    send_word(2, 1'b0, w2);
    idle(10);
    check_eq("ovr_valid", rx_word_valid, 1);
    check_eq("ovr_data", rx_word_data, w1);
    check_eq("ovr_flag", overrun_error, 1);
    check_eq("ovr_no_done", done_cyc_q.size(), 0);
    exp_q.push_back(w1);
    rdy_mode = 1;
    wait_done(50, "ovr");
    finish_job("ovr", 1'b1);

    // Back-to-back: held word transfers on the edge the next word completes.
    rdy_mode = 0;
    arm(2);
    send_word(2, 1'b0, w1);
    send_word(2, 1'b1, w2);
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    wait_done(100, "b2b");
    finish_job("b2b", 1'b0);
    if (xfer_cyc_q.size() == 2) check_eq("b2b_adjacent", xfer_cyc_q[1], xfer_cyc_q[0] + 1);

    // Random jobs with random ready.
    for (int j = 0; j < 6; j++) begin
      n = int'($urandom_range(1, 3));
      rdy_mode = 2;
      arm(n);
      for (int k = 0; k < n; k++) begin
        send_word(4, 1'b0, w);
        exp_q.push_back(w);
      end
      wait_done(300, "rand");
      finish_job("rand", 1'b0);
    end

    // Reset in the middle of the second word's first byte.
    rdy_mode = 0;
    arm(2);
    send_word(2, 1'b0, w1);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    resetn = 1'b1;
    tick();
    check_eq("mid_rst_data", rx_word_data, 0);
    check_eq("mid_rst_valid", rx_word_valid, 0);
    check_eq("mid_rst_done", rx_done, 0);
    check_eq("mid_rst_frame", frame_error, 0);
    check_eq("mid_rst_overrun", overrun_error, 0);
    rx = 1'b1;
    idle(2);
    resetn = 1'b0;
    idle(5);
    rdy_mode = 1;
    arm(1);
    send_word(2, 1'b0, w);
    exp_q.push_back(w);
    wait_done(300, "post_rst");
    finish_job("post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
